// File: rtl/dtree_pkg.sv
// rtl/dtree_pkg.sv - shared types and constants for the sequential decision-tree engine
package dtree_pkg;

   localparam int N_FEAT    = 7;
   localparam int FEAT_W    = 8;
   localparam int N_NODES   = 16;
   localparam int PTR_W     = $clog2(N_NODES);
   localparam int CLASS_W   = 5;
   localparam int MAX_STEPS = 15;
   localparam int STEP_W    = $clog2(MAX_STEPS + 1);
   localparam int FIDX_W    = 3;
   localparam int NODE_W    = 1 + 3 + 3 + FEAT_W + 2 * PTR_W;

   localparam int RIGHT_LSB = 0;
   localparam int LEFT_LSB  = PTR_W;
   localparam int THR_LSB   = 2 * PTR_W;
   localparam int SHIFT_LSB = THR_LSB + FEAT_W;
   localparam int FIDX_LSB  = SHIFT_LSB + 3;
   localparam int LEAF_BIT  = FIDX_LSB + 3;

   localparam logic [CLASS_W-1:0] ERR_CLASS = '1;

   typedef struct packed {
      logic              is_leaf;
      logic [2:0]        feat_idx;
      logic [2:0]        shift;
      logic [FEAT_W-1:0] thr;
      logic [PTR_W-1:0]  left;
      logic [PTR_W-1:0]  right;
   } node_t;

   typedef enum logic [1:0] {IDLE, LOAD, WALK, DONE} state_t;

   function automatic logic [NODE_W-1:0] node_pack(
      input logic              leaf,
      input logic [2:0]        fidx,
      input logic [2:0]        shift,
      input logic [FEAT_W-1:0] thr,
      input logic [PTR_W-1:0]  left,
      input logic [PTR_W-1:0]  right
   );
      logic [NODE_W-1:0] w;
      w = '0;
      w[LEAF_BIT]                = leaf;
      w[FIDX_LSB  +: 3]          = fidx;
      w[SHIFT_LSB +: 3]          = shift;
      w[THR_LSB   +: FEAT_W]     = thr;
      w[LEFT_LSB  +: PTR_W]      = left;
      w[RIGHT_LSB +: PTR_W]      = right;
      return w;
   endfunction

endpackage

// File: rtl/dtree_seq_engine_if.sv
// rtl/dtree_seq_engine_if.sv - feature/result streams and node-table write port
interface dtree_seq_engine_if;
   import dtree_pkg::*;

   logic               s_valid;
   logic               s_ready;
   logic [FEAT_W-1:0]  s_data;
   logic               m_valid;
   logic               m_ready;
   logic [CLASS_W-1:0] m_class;
   logic               m_err;
   logic               cfg_we;
   logic [PTR_W-1:0]   cfg_addr;
   logic [NODE_W-1:0]  cfg_wdata;
   logic               cfg_err;

   modport master (
      output s_valid, s_data, m_ready, cfg_we, cfg_addr, cfg_wdata,
      input  s_ready, m_valid, m_class, m_err, cfg_err
   );

   modport slave (
      input  s_valid, s_data, m_ready, cfg_we, cfg_addr, cfg_wdata,
      output s_ready, m_valid, m_class, m_err, cfg_err
   );

endinterface

// File: rtl/dtree_node_cmp.sv
// rtl/dtree_node_cmp.sv - feature select, shift and threshold compare for one node
module dtree_node_cmp
   import dtree_pkg::*;
(
   input  node_t              i_node,
   input  logic [FEAT_W-1:0]  i_feat [N_FEAT],
   output logic               o_is_leaf,
   output logic [CLASS_W-1:0] o_class,
   output logic [PTR_W-1:0]   o_next_ptr
);

   logic [FEAT_W-1:0] w_feat;
   logic [FEAT_W-1:0] w_cmp;

   // Indices past the last feature select zero.
   always_comb begin
      w_feat = '0;
      for (int i = 0; i < N_FEAT; i++) begin
         if (i_node.feat_idx == FIDX_W'(i)) w_feat = i_feat[i];
      end
   end

   assign w_cmp      = w_feat >> i_node.shift;
   assign o_is_leaf  = i_node.is_leaf;
   assign o_class    = i_node.thr[CLASS_W-1:0];
   assign o_next_ptr = (w_cmp <= i_node.thr) ? i_node.left : i_node.right;

endmodule

// File: rtl/dtree_seq_engine.sv
// rtl/dtree_seq_engine.sv - sequential decision-tree classifier walking a register node table
// Optional DTREE_PERF_CNT_EN adds perf_cnt/perf_depth result statistics.
module dtree_seq_engine
   import dtree_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   dtree_seq_engine_if.slave  bus,
   output logic               busy
`ifdef DTREE_PERF_CNT_EN
   ,
   output logic [15:0]        perf_cnt,
   output logic [3:0]         perf_depth
`endif
);

   localparam logic [NODE_W-1:0] LEAF0 = node_pack(1'b1, 3'd0, 3'd0, '0, '0, '0);

   state_t             r_state;
   logic [FEAT_W-1:0]  r_feat  [N_FEAT];
   logic [NODE_W-1:0]  r_nodes [N_NODES];
   logic [PTR_W-1:0]   r_ptr;
   logic [STEP_W-1:0]  r_step;
   logic [FIDX_W-1:0]  r_fidx;
   logic               r_s_ready;
   logic               r_m_valid;
   logic [CLASS_W-1:0] r_class;
   logic               r_err;
   logic               r_cfg_err;
   logic               r_busy;

   node_t              w_node;
   logic               w_is_leaf;
   logic [CLASS_W-1:0] w_leaf_class;
   logic [PTR_W-1:0]   w_next_ptr;
   logic               w_s_hs;
   logic               w_cfg_ok;

   // Pointers beyond a non-power-of-two table read as a class-0 leaf.
   assign w_node   = (32'(r_ptr) < N_NODES) ? node_t'(r_nodes[r_ptr]) : node_t'(LEAF0);
   assign w_s_hs   = bus.s_valid && r_s_ready;
   assign w_cfg_ok = bus.cfg_we && (r_state == IDLE) && !w_s_hs && (32'(bus.cfg_addr) < N_NODES);

   dtree_node_cmp u_cmp (
      .i_node     (w_node),
      .i_feat     (r_feat),
      .o_is_leaf  (w_is_leaf),
      .o_class    (w_leaf_class),
      .o_next_ptr (w_next_ptr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_step    <= '0;
         r_fidx    <= '0;
         r_s_ready <= 1'b1;
         r_m_valid <= 1'b0;
         r_class   <= '0;
         r_err     <= 1'b0;
         r_cfg_err <= 1'b0;
         r_busy    <= 1'b0;
         for (int i = 0; i < N_FEAT; i++) r_feat[i] <= '0;
         for (int i = 0; i < N_NODES; i++) r_nodes[i] <= LEAF0;
      end else begin
         r_cfg_err <= bus.cfg_we && !w_cfg_ok;
         if (w_cfg_ok) r_nodes[bus.cfg_addr] <= bus.cfg_wdata;

         case (r_state)
            IDLE: begin
               if (w_s_hs) begin
                  r_feat[0] <= bus.s_data;
                  r_busy    <= 1'b1;
                  if (N_FEAT == 1) begin
                     r_state   <= WALK;
                     r_s_ready <= 1'b0;
                     r_ptr     <= '0;
                     r_step    <= '0;
                  end else begin
                     r_state <= LOAD;
                     r_fidx  <= FIDX_W'(1);
                  end
               end
            end
            LOAD: begin
               if (w_s_hs) begin
                  r_feat[r_fidx] <= bus.s_data;
                  if (r_fidx == FIDX_W'(N_FEAT - 1)) begin
                     r_state   <= WALK;
                     r_s_ready <= 1'b0;
                     r_ptr     <= '0;
                     r_step    <= '0;
                  end else begin
                     r_fidx <= r_fidx + 1'b1;
                  end
               end
            end
            WALK: begin
               if (w_is_leaf) begin
                  r_class   <= w_leaf_class;
                  r_err     <= 1'b0;
                  r_m_valid <= 1'b1;
                  r_state   <= DONE;
               end else if (r_step == STEP_W'(MAX_STEPS)) begin
                  // Step guard stops cyclic or over-deep tables.
                  r_class   <= ERR_CLASS;
                  r_err     <= 1'b1;
                  r_m_valid <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_ptr  <= w_next_ptr;
                  r_step <= r_step + 1'b1;
               end
            end
            DONE: begin
               if (bus.m_ready) begin
                  r_m_valid <= 1'b0;
                  r_s_ready <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.s_ready = r_s_ready;
   assign bus.m_valid = r_m_valid;
   assign bus.m_class = r_class;
   assign bus.m_err   = r_err;
   assign bus.cfg_err = r_cfg_err;
   assign busy        = r_busy;

`ifdef DTREE_PERF_CNT_EN
   logic [15:0] r_perf_cnt;
   logic [3:0]  r_perf_depth;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_cnt   <= '0;
         r_perf_depth <= '0;
      end else if ((r_state == DONE) && bus.m_ready) begin
         if (r_perf_cnt != 16'hFFFF) r_perf_cnt <= r_perf_cnt + 16'd1;
         r_perf_depth <= r_step;
      end
   end

   assign perf_cnt   = r_perf_cnt;
   assign perf_depth = r_perf_depth;
`endif

endmodule

// File: tb/tb_dtree_seq_engine.sv
// tb/tb_dtree_seq_engine.sv - scoreboard bench for dtree_seq_engine
`timescale 1ns/1ps
module tb_dtree_seq_engine;
   import dtree_pkg::*;

   localparam logic [NODE_W-1:0] N_ROOT = {1'b0, 3'd6, 3'd5, 8'd0,  4'd1, 4'd2};
   localparam logic [NODE_W-1:0] LEAF19 = {1'b1, 3'd0, 3'd0, 8'd19, 4'd0, 4'd0};
   localparam logic [NODE_W-1:0] LEAF25 = {1'b1, 3'd0, 3'd0, 8'd25, 4'd0, 4'd0};
   localparam logic [NODE_W-1:0] LEAF5  = {1'b1, 3'd0, 3'd0, 8'd5,  4'd0, 4'd0};
   localparam logic [NODE_W-1:0] LOOP0  = {1'b0, 3'd0, 3'd0, 8'd0,  4'd0, 4'd0};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
`ifdef DTREE_PERF_CNT_EN
   logic [15:0] perf_cnt;
   logic [3:0]  perf_depth;
`endif

   dtree_seq_engine_if u_if ();

   dtree_seq_engine u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave),
      .busy  (busy)
`ifdef DTREE_PERF_CNT_EN
      ,
      .perf_cnt   (perf_cnt),
      .perf_depth (perf_depth)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CLASS_W-1:0] cls;
      logic               err;
      int                 lat;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_sent   = 0;
   int   cyc      = 0;
   int   t_last   = 0;
   int   t_rise   = 0;
   int   beats    = 0;
   logic prev_valid = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: timestamps the last feature beat and the m_valid rise, pops on each result handshake.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         beats      = 0;
         prev_valid = 1'b0;
      end else begin
         if (u_if.s_valid && u_if.s_ready) begin
            beats++;
            if (beats == N_FEAT) begin
               beats  = 0;
               t_last = cyc;
            end
         end
         if (u_if.m_valid && !prev_valid) t_rise = cyc;
         if (u_if.m_valid && u_if.m_ready) begin
            chk("sb_has_entry", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               chk("m_class", 32'(u_if.m_class), 32'(mon_e.cls));
               chk("m_err", 32'(u_if.m_err), 32'(mon_e.err));
               if (mon_e.lat >= 0) chk("latency", 32'(t_rise - t_last), 32'(mon_e.lat));
            end
         end
         prev_valid = u_if.m_valid;
      end
   end

   task automatic send_sample(input logic [N_FEAT*FEAT_W-1:0] f, input logic [CLASS_W-1:0] cls,
                              input logic err, input int lat, input bit cfg_clash);
      exp_t e;
      e.cls = cls;
      e.err = err;
      e.lat = lat;
      sb_q.push_back(e);
      n_sent++;
      for (int i = 0; i < N_FEAT; i++) begin
         int g;
         g = 0;
         u_if.s_valid = 1'b1;
         u_if.s_data  = f[i*FEAT_W +: FEAT_W];
         if (cfg_clash && i == 0) begin
            u_if.cfg_we    = 1'b1;
            u_if.cfg_addr  = 4'd1;
            u_if.cfg_wdata = LEAF5;
         end
         @(negedge clk);
         while (!u_if.s_ready && g < 100) begin
            @(negedge clk);
            g++;
         end
         if (g >= 100) chk("s_ready_timeout", 32'(g), 0);
         @(posedge clk);
         #1;
         if (cfg_clash && i == 0) begin
            u_if.cfg_we = 1'b0;
            chk("cfg_err_beat_clash", 32'(u_if.cfg_err), 1);
         end
      end
      u_if.s_valid = 1'b0;
   endtask

   task automatic cfg_write(input logic [PTR_W-1:0] a, input logic [NODE_W-1:0] d,
                            input logic exp_err, input string tag);
      u_if.cfg_we    = 1'b1;
      u_if.cfg_addr  = a;
      u_if.cfg_wdata = d;
      @(posedge clk);
      #1;
      u_if.cfg_we = 1'b0;
      chk(tag, 32'(u_if.cfg_err), 32'(exp_err));
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((sb_q.size() != 0 || u_if.m_valid) && g < 300) begin
         @(posedge clk);
         #1;
         g++;
      end
      chk("drain_sb_empty", 32'(sb_q.size()), 0);
   endtask

   initial begin
      int g;
      u_if.s_valid   = 1'b0;
      u_if.s_data    = '0;
      u_if.m_ready   = 1'b1;
      u_if.cfg_we    = 1'b0;
      u_if.cfg_addr  = '0;
      u_if.cfg_wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", 32'(u_if.s_ready), 1);
      chk("rst_m_valid", 32'(u_if.m_valid), 0);
      chk("rst_m_class", 32'(u_if.m_class), 0);
      chk("rst_m_err", 32'(u_if.m_err), 0);
      chk("rst_cfg_err", 32'(u_if.cfg_err), 0);
      chk("rst_busy", 32'(busy), 0);
`ifdef DTREE_PERF_CNT_EN
      chk("rst_perf_cnt", 32'(perf_cnt), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      send_sample('0, 5'd0, 1'b0, 2, 1'b0);
      drain();

      cfg_write(4'd0, N_ROOT, 1'b0, "cfg_ok_n0");
      cfg_write(4'd1, LEAF19, 1'b0, "cfg_ok_n1");
      cfg_write(4'd2, LEAF25, 1'b0, "cfg_ok_n2");
      send_sample({8'h10, 48'h0}, 5'd19, 1'b0, 3, 1'b0);
      drain();
`ifdef DTREE_PERF_CNT_EN
      chk("perf_depth_leaf1", 32'(perf_depth), 1);
`endif
      send_sample({8'hE0, 48'h0}, 5'd25, 1'b0, 3, 1'b0);
      send_sample({8'h1F, 48'h0}, 5'd19, 1'b0, 3, 1'b0);
      send_sample({8'h20, 48'h0}, 5'd25, 1'b0, 3, 1'b0);
      drain();

      cfg_write(4'd0, LOOP0, 1'b0, "cfg_ok_loop");
      send_sample('0, 5'd31, 1'b1, -1, 1'b0);
      drain();
      cfg_write(4'd0, N_ROOT, 1'b0, "cfg_ok_restore");

      u_if.m_ready = 1'b0;
      send_sample({8'h10, 48'h0}, 5'd19, 1'b0, 3, 1'b0);
      g = 0;
      @(negedge clk);
      while (!u_if.m_valid && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("stall_wait_valid", 32'(u_if.m_valid), 1);
      for (int k = 0; k < 5; k++) begin
         chk("stall_m_valid", 32'(u_if.m_valid), 1);
         chk("stall_m_class", 32'(u_if.m_class), 19);
         chk("stall_s_ready", 32'(u_if.s_ready), 0);
         chk("stall_busy", 32'(busy), 1);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      u_if.m_ready = 1'b1;
      send_sample({8'hE0, 48'h0}, 5'd25, 1'b0, 3, 1'b0);
      drain();

      send_sample({8'h10, 48'h0}, 5'd19, 1'b0, 3, 1'b0);
      cfg_write(4'd1, LEAF5, 1'b1, "cfg_err_walk");
      @(posedge clk);
      #1;
      chk("cfg_err_one_cycle", 32'(u_if.cfg_err), 0);
      drain();
      send_sample({8'h10, 48'h0}, 5'd19, 1'b0, 3, 1'b1);
      drain();
      send_sample({8'h10, 48'h0}, 5'd19, 1'b0, 3, 1'b0);
      drain();
`ifdef DTREE_PERF_CNT_EN
      chk("perf_cnt_total", 32'(perf_cnt), 32'(n_sent));
`endif

      for (int i = 0; i < 3; i++) begin
         u_if.s_valid = 1'b1;
         u_if.s_data  = 8'h55;
         @(posedge clk);
         #1;
      end
      u_if.s_valid = 1'b0;
      chk("partial_busy", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_s_ready", 32'(u_if.s_ready), 1);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_m_valid", 32'(u_if.m_valid), 0);
      chk("midrst_m_class", 32'(u_if.m_class), 0);
`ifdef DTREE_PERF_CNT_EN
      chk("midrst_perf_cnt", 32'(perf_cnt), 0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_sample({8'hE0, 48'h0}, 5'd0, 1'b0, 2, 1'b0);
      drain();
`ifdef DTREE_PERF_CNT_EN
      chk("perf_cnt_after_rst", 32'(perf_cnt), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
